// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 lines, deframes
// 11-bit frames and folds F0/E0 prefixes into a held scan code plus make/break and extended flags.
module ps2_scancode_rx #(
    parameter int FILT_LEN       = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       state,
    output logic       extended,
    output logic       code_valid,
    output logic       frame_err,
    output logic [1:0] dbg_fsm
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } fsm_t;

    // Handshake: code_valid and frame_err are single-cycle strobes with no ready;
    // code/state/extended are valid in the code_valid cycle and held afterwards.

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    fsm_t          fsm_q, fsm_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          brk_pend_q, brk_pend_d;
    logic          ext_pend_q, ext_pend_d;
    logic [7:0]    code_q, code_d;
    logic          make_q, make_d;
    logic          ext_q, ext_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          fall;

    // Idle PS/2 lines are high, so the synchronisers reset to 1 as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            fsm_q      <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            code_q     <= '0;
            make_q     <= 1'b0;
            ext_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            fsm_q      <= fsm_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            brk_pend_q <= brk_pend_d;
            ext_pend_q <= ext_pend_d;
            code_q     <= code_d;
            make_q     <= make_d;
            ext_q      <= ext_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // fall is asserted in the cycle the filter accepts a 1->0 change.
    assign fall = filt_q && !clk_s2_q && (fcnt_q == FILT_LAST);

    always_comb begin
        filt_d     = filt_q;
        fcnt_d     = '0;
        fsm_d      = fsm_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        brk_pend_d = brk_pend_q;
        ext_pend_d = ext_pend_q;
        code_d     = code_q;
        make_d     = make_q;
        ext_d      = ext_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FILT_LAST) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        if (fsm_q == S_IDLE || fall) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d = '0;
            fsm_d = S_IDLE;
            err_d = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (fall) begin
            case (fsm_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        fsm_d     = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        fsm_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d = dat_s2_q;
                    fsm_d = S_STOP;
                end
                S_STOP: begin
                    fsm_d = S_IDLE;
                    if (dat_s2_q && (^shift_q ^ par_q)) begin
                        if (shift_q == 8'hF0) begin
                            brk_pend_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else begin
                            code_d     = shift_q;
                            make_d     = !brk_pend_q;
                            ext_d      = ext_pend_q;
                            valid_d    = 1'b1;
                            brk_pend_d = 1'b0;
                            ext_pend_d = 1'b0;
                        end
                    end else begin
                        err_d      = 1'b1;
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                    end
                end
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    assign code       = code_q;
    assign state      = make_q;
    assign extended   = ext_q;
    assign code_valid = valid_q;
    assign frame_err  = err_q;
    assign dbg_fsm    = fsm_q;

endmodule
